// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types for the arbiter output stage.
//   arb_entry_t  : layout of one buffered word at the default 32-bit data width
//                  (data in the MSBs, source tag in the LSB). arb_out_fifo packs
//                  entries as a flat vector in exactly this order so that other
//                  DW settings keep the same layout.
//   fifo_state_e : frame-tracking FSM states.
//   MODE_NONE    : mode encoding for "no mode".
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_DW       = 32;
    localparam int ENTRY_CTRL_W = 11;    // mode(2) + proc_val(8) + source(1)

    typedef struct packed {
        logic [ARB_DW-1:0] data;
        logic [1:0]        mode;
        logic [7:0]        proc_val;
        logic              source;
    } arb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        CMPLT  = 2'd2
    } fifo_state_e;

    localparam logic [1:0] MODE_NONE = 2'b00;

endpackage : arb_pkg

// File: rtl/arb_fifo_mem.sv
// -----------------------------------------------------------------------------
// arb_fifo_mem
// DEPTH x EW register-array storage: one synchronous write port and one
// asynchronous (combinational) read port. Contents are deliberately not reset;
// the owner qualifies the read data with its own valid.
// Ports:
//   clk      in   clock
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  combinational read of rd_addr
// -----------------------------------------------------------------------------
module arb_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int EW    = 43
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [EW-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [EW-1:0]            rd_data
);

    logic [EW-1:0] mem_r [DEPTH];

    // Storage write port; no reset so the array maps onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule : arb_fifo_mem

// File: rtl/arb_out_fifo.sv
// -----------------------------------------------------------------------------
// arb_out_fifo
// Buffers the arbitrated word stream from the two-slave arbiter, returns
// fifo_full as backpressure, presents the head entry show-ahead to the master
// with valid/ready, and counts drained words per frame. When a frame's worth of
// words has been popped, mstr0_cmplt is raised and further words are withheld
// (mstr_valid=0) until cmplt_ack.
//
// Optional feature (macro ARB_OUT_FIFO_SRC_STATS_EN): adds src0_words and
// src1_words, per-frame counts of accepted pushes per source tag.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   slvx_*            arbitrated word (data, mode, proc value), data_source tag
//   slvx_data_valid   push request
//   fifo_full         backpressure to arbiter (registered)
//   frame_len         words per frame, sampled on IDLE->ACTIVE (0 means 1)
//   mstr_*            head entry fields, mstr_valid / mstr_ready handshake
//   mstr0_cmplt       frame complete, held until cmplt_ack
//   cmplt_ack         completion acknowledge (ignored outside CMPLT)
//   fifo_count        current occupancy 0..DEPTH
//   src0/1_words      (optional) per-frame push counts per source
// -----------------------------------------------------------------------------
module arb_out_fifo
    import arb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int FLW   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW-1:0]            slvx_data,
    input  logic [1:0]               slvx_mode,
    input  logic [7:0]               slvx_proc_val,
    input  logic                     data_source,
    input  logic                     slvx_data_valid,
    output logic                     fifo_full,
    input  logic [FLW-1:0]           frame_len,
    output logic [DW-1:0]            mstr_data,
    output logic [1:0]               mstr_mode,
    output logic [7:0]               mstr_proc_val,
    output logic                     mstr_source,
    output logic                     mstr_valid,
    input  logic                     mstr_ready,
    output logic                     mstr0_cmplt,
    input  logic                     cmplt_ack,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ARB_OUT_FIFO_SRC_STATS_EN
    ,
    output logic [FLW-1:0]           src0_words,
    output logic [FLW-1:0]           src1_words
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DW + ENTRY_CTRL_W;

    localparam logic [AW-1:0]  PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
    localparam logic [FLW-1:0] FL_ONE   = {{(FLW-1){1'b0}}, 1'b1};
    localparam logic [FLW-1:0] FL_ZERO  = {FLW{1'b0}};

    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_nxt_s;
    logic           full_r;
    fifo_state_e    state_r;
    fifo_state_e    state_nxt_s;
    logic [FLW-1:0] flen_r;
    logic [FLW-1:0] flen_nxt_s;
    logic [FLW-1:0] fcnt_r;
    logic [FLW-1:0] fcnt_nxt_s;
    logic           cmplt_r;
    logic           cmplt_nxt_s;
    logic           push_s;
    logic           pop_s;
    logic           valid_s;
    logic [EW-1:0]  wr_entry_s;
    logic [EW-1:0]  rd_entry_s;

    // Full is judged on the registered flag, so a push alongside a pop from
    // full is refused.
    assign push_s  = slvx_data_valid && !full_r;
    // Words are withheld while a completed frame awaits acknowledge.
    assign valid_s = (count_r != CNT_ZERO) && (state_r != CMPLT);
    assign pop_s   = valid_s && mstr_ready;

    // Entry order: data, mode, proc_val, source (source in the LSB).
    assign wr_entry_s = {slvx_data, slvx_mode, slvx_proc_val, data_source};

    arb_fifo_mem #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_entry_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_entry_s)
    );

    assign mstr_data     = rd_entry_s[EW-1 -: DW];
    assign mstr_mode     = rd_entry_s[10:9];
    assign mstr_proc_val = rd_entry_s[8:1];
    assign mstr_source   = rd_entry_s[0];
    assign mstr_valid    = valid_s;
    assign fifo_full     = full_r;
    assign mstr0_cmplt   = cmplt_r;
    assign fifo_count    = count_r;

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
        end
    end

    // Frame FSM next-state logic: IDLE starts a frame as soon as anything is
    // pushed or already buffered; ACTIVE counts pops; CMPLT waits for ack.
    always_comb begin
        state_nxt_s = state_r;
        flen_nxt_s  = flen_r;
        fcnt_nxt_s  = fcnt_r;
        cmplt_nxt_s = cmplt_r;
        case (state_r)
            IDLE: begin
                if (push_s || (count_r != CNT_ZERO)) begin
                    state_nxt_s = ACTIVE;
                    flen_nxt_s  = (frame_len == FL_ZERO) ? FL_ONE : frame_len;
                    fcnt_nxt_s  = FL_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACTIVE: begin
                if (pop_s) begin
                    fcnt_nxt_s = fcnt_r + FL_ONE;
                    if (fcnt_r == (flen_r - FL_ONE)) begin
                        state_nxt_s = CMPLT;
                        cmplt_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ACTIVE;
                    end
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            CMPLT: begin
                if (cmplt_ack) begin
                    state_nxt_s = IDLE;
                    cmplt_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = CMPLT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cmplt_nxt_s = 1'b0;
            end
        endcase
    end

    // Frame FSM state and frame bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            flen_r  <= FL_ZERO;
            fcnt_r  <= FL_ZERO;
            cmplt_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            flen_r  <= flen_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
            cmplt_r <= cmplt_nxt_s;
        end
    end

`ifdef ARB_OUT_FIFO_SRC_STATS_EN
    logic           ack_acc_s;
    logic [FLW-1:0] src0_inc_s;
    logic [FLW-1:0] src1_inc_s;
    logic [FLW-1:0] src0_r;
    logic [FLW-1:0] src1_r;

    assign ack_acc_s  = (state_r == CMPLT) && cmplt_ack;
    assign src0_inc_s = {{(FLW-1){1'b0}}, (push_s && !data_source)};
    assign src1_inc_s = {{(FLW-1){1'b0}}, (push_s &&  data_source)};

    // Per-source push counters; a push landing on the ack cycle already
    // belongs to the next frame, so it seeds the cleared count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src0_r <= FL_ZERO;
            src1_r <= FL_ZERO;
        end else if (ack_acc_s) begin
            src0_r <= src0_inc_s;
            src1_r <= src1_inc_s;
        end else begin
            src0_r <= src0_r + src0_inc_s;
            src1_r <= src1_r + src1_inc_s;
        end
    end

    assign src0_words = src0_r;
    assign src1_words = src1_r;
`endif

endmodule : arb_out_fifo

// File: tb/tb_arb_out_fifo.sv
// -----------------------------------------------------------------------------
// tb_arb_out_fifo
// Self-checking bench for arb_out_fifo. A driver applies directed and random
// stimulus one cycle at a time and advances a queue-based reference model;
// accepted pushes are queued as expected words, and an independent monitor
// pops and compares them whenever the DUT completes a handshake.
// -----------------------------------------------------------------------------
module tb_arb_out_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int FLW   = 16;

    logic           clk;
    logic           rst_n;
    logic [DW-1:0]  slvx_data;
    logic [1:0]     slvx_mode;
    logic [7:0]     slvx_proc_val;
    logic           data_source;
    logic           slvx_data_valid;
    logic           fifo_full;
    logic [FLW-1:0] frame_len;
    logic [DW-1:0]  mstr_data;
    logic [1:0]     mstr_mode;
    logic [7:0]     mstr_proc_val;
    logic           mstr_source;
    logic           mstr_valid;
    logic           mstr_ready;
    logic           mstr0_cmplt;
    logic           cmplt_ack;
    logic [4:0]     fifo_count;
`ifdef ARB_OUT_FIFO_SRC_STATS_EN
    logic [FLW-1:0] src0_words;
    logic [FLW-1:0] src1_words;
`endif

    arb_out_fifo #(.DW(DW), .DEPTH(DEPTH), .FLW(FLW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .slvx_data       (slvx_data),
        .slvx_mode       (slvx_mode),
        .slvx_proc_val   (slvx_proc_val),
        .data_source     (data_source),
        .slvx_data_valid (slvx_data_valid),
        .fifo_full       (fifo_full),
        .frame_len       (frame_len),
        .mstr_data       (mstr_data),
        .mstr_mode       (mstr_mode),
        .mstr_proc_val   (mstr_proc_val),
        .mstr_source     (mstr_source),
        .mstr_valid      (mstr_valid),
        .mstr_ready      (mstr_ready),
        .mstr0_cmplt     (mstr0_cmplt),
        .cmplt_ack       (cmplt_ack),
        .fifo_count      (fifo_count)
`ifdef ARB_OUT_FIFO_SRC_STATS_EN
        ,
        .src0_words      (src0_words),
        .src1_words      (src1_words)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        logic [7:0]  p;
        logic        s;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model: occupancy, frame phase (0 idle, 1 active, 2 complete)
    int m_count;
    bit m_full;
    int m_phase;
    int m_flen;
    int m_fpops;
    int m_s0;
    int m_s1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        return (m_count != 0) && (m_phase != 2);
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_full  = 1'b0;
        m_phase = 0;
        m_flen  = 0;
        m_fpops = 0;
        m_s0    = 0;
        m_s1    = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs that were just applied.
    task automatic model_step();
        bit   push;
        bit   pop;
        exp_t e;
        push = slvx_data_valid && !m_full;
        pop  = m_valid() && mstr_ready;
        if (push) begin
            e.d = slvx_data;
            e.m = slvx_mode;
            e.p = slvx_proc_val;
            e.s = data_source;
            exp_q.push_back(e);
        end
        if (m_phase == 2 && cmplt_ack) begin
            m_s0 = (push && !data_source) ? 1 : 0;
            m_s1 = (push &&  data_source) ? 1 : 0;
        end else begin
            m_s0 = (m_s0 + ((push && !data_source) ? 1 : 0)) % 65536;
            m_s1 = (m_s1 + ((push &&  data_source) ? 1 : 0)) % 65536;
        end
        if (m_phase == 0) begin
            if (push || m_count != 0) begin
                m_phase = 1;
                m_flen  = (frame_len == 0) ? 1 : int'(frame_len);
                m_fpops = 0;
            end
        end else if (m_phase == 1) begin
            if (pop) begin
                m_fpops++;
                if (m_fpops == m_flen) m_phase = 2;
            end
        end else begin
            if (cmplt_ack) m_phase = 0;
        end
        m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
        m_full  = (m_count == DEPTH);
    endtask

    task automatic check_outputs();
        check("mstr_valid",  64'(mstr_valid),  64'(m_valid()));
        check("fifo_full",   64'(fifo_full),   64'(m_full));
        check("fifo_count",  64'(fifo_count),  64'(m_count));
        check("mstr0_cmplt", 64'(mstr0_cmplt), 64'(m_phase == 2));
`ifdef ARB_OUT_FIFO_SRC_STATS_EN
        check("src0_words",  64'(src0_words),  64'(m_s0));
        check("src1_words",  64'(src1_words),  64'(m_s1));
`endif
    endtask

    // One clock: apply inputs, check at the falling edge, step model after rise.
    task automatic cyc(input bit v, input logic [31:0] d, input bit s, input bit r, input bit a);
        slvx_data_valid = v;
        slvx_data       = d;
        slvx_mode       = 2'($urandom_range(3, 0));
        slvx_proc_val   = 8'($urandom_range(255, 0));
        data_source     = s;
        mstr_ready      = r;
        cmplt_ack       = a;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        slvx_data_valid = 1'b0;
        mstr_ready      = 1'b0;
        cmplt_ack       = 1'b0;
        #1;
        check("rst_fifo_full",  64'(fifo_full),   64'd0);
        check("rst_mstr_valid", 64'(mstr_valid),  64'd0);
        check("rst_fifo_count", 64'(fifo_count),  64'd0);
        check("rst_cmplt",      64'(mstr0_cmplt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed handshake must deliver the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && mstr_valid && mstr_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL mon_underflow: got word %0h expected none (t=%0t)", mstr_data, $time);
            end else begin
                check("mstr_data", 64'(mstr_data), 64'(exp_q[0].d));
                check("mstr_tag", 64'({mstr_mode, mstr_proc_val, mstr_source}),
                      64'({exp_q[0].m, exp_q[0].p, exp_q[0].s}));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        slvx_data       = 32'd0;
        slvx_mode       = 2'd0;
        slvx_proc_val   = 8'd0;
        data_source     = 1'b0;
        slvx_data_valid = 1'b0;
        frame_len       = 16'd4;
        mstr_ready      = 1'b0;
        cmplt_ack       = 1'b0;
        model_reset();
        do_reset();

        // Reset mid-frame, then a single word appears one cycle after its push
        cyc(1'b1, 32'h1111_0001, 1'b0, 1'b0, 1'b0);
        do_reset();
        cyc(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Fill to full, drop a 17th word, push+pop at full, then drain
        do_reset();
        frame_len = 16'd100;
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 32'(i), 1'(i % 2), 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD_0017, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hBEEF_0018, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Frame of 4 with 6 words streamed; remainder held until acknowledge
        do_reset();
        frame_len = 16'd4;
        for (int i = 1; i <= 6; i++) cyc(1'b1, 32'h0000_0100 + 32'(i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Zero frame length behaves as a frame of one word
        do_reset();
        frame_len = 16'd0;
        cyc(1'b1, 32'h0000_0ABC, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Per-source counts: 3 from source 0, 2 from source 1, then ack
        do_reset();
        frame_len = 16'd5;
        cyc(1'b1, 32'h0000_0A01, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0B01, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0A02, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0B02, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0A03, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Random traffic with random frame lengths and acknowledges
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i % 97 == 0) frame_len = 16'($urandom_range(6, 0));
            cyc(($urandom_range(99, 0) < 60), $urandom, 1'($urandom_range(1, 0)),
                ($urandom_range(99, 0) < ((i / 400) % 2 == 0 ? 70 : 25)),
                ($urandom_range(99, 0) < 20));
        end
        for (int i = 0; i < 40; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, (i % 4 == 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_arb_out_fifo

// File: doc/arb_out_fifo.md
Name: arb_out_fifo

Overview:
- Stage directly downstream of the two-slave arbiter.
- Buffers the arbitrated word stream (data, mode, proc value, source tag) and returns fifo_full to the arbiter as backpressure.
- Presents words to the master/processing side with a valid/ready handshake.
- Counts drained words per frame and raises mstr0_cmplt, which the arbiter uses to stop granting until the frame is acknowledged.

Parameters:
- DW, 32, data word width (matches arbiter DW)
- DEPTH, 16, FIFO entries; power of two, >= 2
- FLW, 16, width of frame_len and the frame counter

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- slvx_data  in  DW  arbitrated data word
- slvx_mode  in  2  mode of current word
- slvx_proc_val  in  8  processing value of current word
- data_source  in  1  0 = slv0, 1 = slv1
- slvx_data_valid  in  1  push request
- fifo_full  out  1  backpressure to arbiter
- frame_len  in  FLW  words per frame; sampled on IDLE->ACTIVE
- mstr_data  out  DW  head-entry data
- mstr_mode  out  2  head-entry mode
- mstr_proc_val  out  8  head-entry proc value
- mstr_source  out  1  head-entry source tag
- mstr_valid  out  1  head entry available
- mstr_ready  in  1  master accepts head entry
- mstr0_cmplt  out  1  frame complete, held until acknowledged
- cmplt_ack  in  1  master acknowledges completion
- fifo_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage and pointers:
  - Entry = {data, mode, proc_val, source}, DW+11 bits.
  - Circular register array; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally.
  - count is held separately, range 0..DEPTH.
- Push:
  - push = slvx_data_valid && !fifo_full.
  - Entry written at wr_ptr on the clock edge.
  - A word with valid=1 while full is dropped; the arbiter must hold its data.
- fifo_full = (count == DEPTH), registered and updated the same edge as count.
  - Deasserts the cycle after a pop from full.
  - A push in the same cycle as a pop from full is still refused, because full is evaluated before the edge.
- Output path:
  - Show-ahead: mstr_* outputs are the combinational read of the entry at rd_ptr.
  - mstr_valid = (count != 0) && state != CMPLT.
  - pop = mstr_valid && mstr_ready.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Empty: there is no fall-through bypass. A pushed word becomes visible on mstr_valid the cycle after the push (latency 1).
- FSM, with next state registered:
  - IDLE:
    - On the first push, latch flen = (frame_len == 0) ? 1 : frame_len, clear fcnt, go to ACTIVE.
    - Pops are allowed in IDLE only if entries remain; they are not counted.
  - ACTIVE:
    - Each pop increments fcnt.
    - A pop when fcnt == flen-1 goes to CMPLT and sets mstr0_cmplt=1 on the next edge.
  - CMPLT:
    - mstr0_cmplt=1 and mstr_valid forced 0, so the next frame's words are not released.
    - Pushes are still accepted into the FIFO.
    - cmplt_ack=1 goes to IDLE; mstr0_cmplt drops the next cycle.
  - cmplt_ack outside CMPLT is ignored.
  - In IDLE, the first-push detection also fires if entries are already buffered: entering IDLE with count != 0 immediately goes to ACTIVE using the current frame_len.
- Reset (async, any time, including mid-frame):
  - Pointers, count, fcnt, flen = 0.
  - State = IDLE.
  - fifo_full = 0, mstr0_cmplt = 0, mstr_valid = 0.
  - Memory contents are not reset; mstr_data and the other mstr_* fields are don't-care while mstr_valid = 0.

Optional Feature:
- Macro: ARB_OUT_FIFO_SRC_STATS_EN.
- With the macro defined:
  - Extra outputs src0_words and src1_words, each FLW bits.
  - Each counts pushes tagged data_source = 0 or 1 respectively during the current frame, wrapping on overflow.
  - Both are cleared on reset and on the cycle cmplt_ack is accepted.
- Without the macro: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package arb_pkg:
  - Typedef arb_entry_t (packed struct of data, mode, proc_val, source).
  - Enum fifo_state_e {IDLE, ACTIVE, CMPLT}.
  - Mode constants MODE_NONE = 2'b00.
- Sub-module arb_fifo_mem: DEPTH x entry storage with write port and async read port.
- Pointer, count and FSM logic remain in the top module.

Test Plan:
- Reset: 1 push, then rst_n low mid-cycle -> fifo_full=0, mstr_valid=0 and count=0 immediately; after release, a new push of 0xA5A5A5A5 appears the cycle after the push.
- Fill: 16 pushes with DEPTH=16 and mstr_ready=0 -> fifo_full=1 after the 16th; a 17th word (0xDEAD0017) with valid is dropped; drain returns words 1..16 in order.
- Full plus simultaneous: at full, push and pop in the same cycle -> push refused, count=15, fifo_full=0 next cycle.
- Frame: frame_len=4, stream 6 words with mstr_ready=1 -> mstr0_cmplt rises after the 4th pop; words 5-6 are held with mstr_valid=0 until cmplt_ack, then released as a new frame.
- Frame length zero: frame_len=0, 1 word -> mstr0_cmplt after 1 pop.
- With ARB_OUT_FIFO_SRC_STATS_EN: 3 words from source 0 and 2 from source 1 -> src0_words=3 and src1_words=2; both read 0 after cmplt_ack.
